// File: rtl/sc_levelcontroller_pkg.sv
// Shared definitions for the level controller: FSM encoding and datapath widths.
package sc_levelcontroller_pkg;

  localparam int unsigned LEVEL_WIDTH     = 2;
  localparam int unsigned COUNT_WIDTH     = 8;
  localparam int unsigned PRESCALER_WIDTH = 25;

  localparam logic [LEVEL_WIDTH-1:0] MAX_LEVEL = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_LEVELUP = 3'd2,
    ST_PAUSE   = 3'd3,
    ST_MAX     = 3'd4
  } state_t;

endpackage

// File: rtl/sc_tickgen.sv
// Game-step prescaler: counts 0..period-1 while enabled and emits a registered 1-cycle tick.
module sc_tickgen
  import sc_levelcontroller_pkg::*;
(
  input  logic                       SC_TICKGEN_CLOCK_50,
  input  logic                       SC_TICKGEN_RESET_InLow,
  input  logic [PRESCALER_WIDTH-1:0] period,
  input  logic                       enable,
  input  logic                       clear,
  output logic                       tick
);

  logic [PRESCALER_WIDTH-1:0] cnt;
  logic [PRESCALER_WIDTH-1:0] last;

  assign last = period - PRESCALER_WIDTH'(1);

  always_ff @(posedge SC_TICKGEN_CLOCK_50 or negedge SC_TICKGEN_RESET_InLow) begin
    if (!SC_TICKGEN_RESET_InLow) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (clear) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (enable) begin
      // >= guards against a period shrinking below the current count
      if (cnt >= last) begin
        cnt  <= '0;
        tick <= 1'b1;
      end else begin
        cnt  <= cnt + PRESCALER_WIDTH'(1);
        tick <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/sc_levelcontroller.sv
// Level controller: game FSM, point counter and level mirror driving a 2-bit external level counter.
module sc_levelcontroller
  import sc_levelcontroller_pkg::*;
#(
  parameter int unsigned POINTS_PER_LEVEL = 4,
  parameter int unsigned TICK_BASE        = 25000000
) (
  input  logic                   SC_LEVELCONTROLLER_CLOCK_50,
  input  logic                   SC_LEVELCONTROLLER_RESET_InLow,
  input  logic                   SC_LEVELCONTROLLER_start_InHigh,
  input  logic                   SC_LEVELCONTROLLER_pause_InHigh,
  input  logic                   SC_LEVELCONTROLLER_point_InHigh,
  output logic                   SC_LEVELCONTROLLER_upLEVEL_Out,
  output logic [LEVEL_WIDTH-1:0] SC_LEVELCONTROLLER_level_OutBUS,
  output logic                   SC_LEVELCONTROLLER_tick_Out,
  output logic                   SC_LEVELCONTROLLER_running_Out
);

  localparam logic [COUNT_WIDTH-1:0]     POINT_LAST  = COUNT_WIDTH'(POINTS_PER_LEVEL - 1);
  localparam logic [PRESCALER_WIDTH-1:0] BASE_PERIOD = PRESCALER_WIDTH'(TICK_BASE);

  state_t                     state, state_nx;
  logic [COUNT_WIDTH-1:0]     count, count_nx;
  logic [LEVEL_WIDTH-1:0]     level, level_nx;
  logic                       up_q;
  logic                       run_now, run_next;
  logic                       tick_en, tick_clr;
  logic [PRESCALER_WIDTH-1:0] period;

  always_ff @(posedge SC_LEVELCONTROLLER_CLOCK_50 or negedge SC_LEVELCONTROLLER_RESET_InLow) begin
    if (!SC_LEVELCONTROLLER_RESET_InLow) begin
      state <= ST_IDLE;
      count <= '0;
      level <= '0;
      up_q  <= 1'b0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      level <= level_nx;
      up_q  <= (state_nx == ST_LEVELUP);
    end
  end

  always_comb begin
    state_nx = state;
    count_nx = count;
    level_nx = level;
    unique case (state)
      ST_IDLE: begin
        if (SC_LEVELCONTROLLER_start_InHigh) state_nx = ST_RUN;
      end
      ST_RUN: begin
        // pause has priority: a coincident point is dropped
        if (SC_LEVELCONTROLLER_pause_InHigh) begin
          state_nx = ST_PAUSE;
        end else if (SC_LEVELCONTROLLER_point_InHigh) begin
          if (count == POINT_LAST) begin
            state_nx = ST_LEVELUP;
            count_nx = '0;
          end else begin
            count_nx = count + COUNT_WIDTH'(1);
          end
        end
      end
      ST_LEVELUP: begin
        level_nx = level + LEVEL_WIDTH'(1);
        state_nx = (level_nx == MAX_LEVEL) ? ST_MAX : ST_RUN;
        if (SC_LEVELCONTROLLER_point_InHigh) count_nx = COUNT_WIDTH'(1);
      end
      ST_PAUSE: begin
        if (!SC_LEVELCONTROLLER_pause_InHigh)
          state_nx = (level == MAX_LEVEL) ? ST_MAX : ST_RUN;
      end
      ST_MAX: begin
        if (SC_LEVELCONTROLLER_pause_InHigh) state_nx = ST_PAUSE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Prescaler only advances while play continues into the next cycle,
  // so no tick can land in LEVELUP or PAUSE.
  assign run_now  = (state == ST_RUN) || (state == ST_MAX);
  assign run_next = (state_nx == ST_RUN) || (state_nx == ST_MAX);
  assign tick_en  = run_now && run_next;
  assign tick_clr = (state == ST_IDLE) || (state == ST_LEVELUP);
  assign period   = BASE_PERIOD >> level;

  sc_tickgen u_tickgen (
    .SC_TICKGEN_CLOCK_50    (SC_LEVELCONTROLLER_CLOCK_50),
    .SC_TICKGEN_RESET_InLow (SC_LEVELCONTROLLER_RESET_InLow),
    .period                 (period),
    .enable                 (tick_en),
    .clear                  (tick_clr),
    .tick                   (SC_LEVELCONTROLLER_tick_Out)
  );

  assign SC_LEVELCONTROLLER_upLEVEL_Out  = up_q;
  assign SC_LEVELCONTROLLER_level_OutBUS = level;
  assign SC_LEVELCONTROLLER_running_Out  = (state == ST_RUN) || (state == ST_LEVELUP) ||
                                           (state == ST_MAX);

endmodule

// File: doc/sc_levelcontroller.md
SC_LEVELCONTROLLER -- requirements
Module: sc_levelcontroller

Interface
REQ-001 Parameter POINTS_PER_LEVEL, default 4, SHALL be the number of point pulses needed per level-up (range 2..255).
REQ-002 Parameter TICK_BASE, default 25000000, SHALL be the level-0 game-step period in clock cycles (minimum 16).
REQ-003 SC_LEVELCONTROLLER_CLOCK_50  in  1  SHALL be the single clock; all logic is rising-edge.
REQ-004 SC_LEVELCONTROLLER_RESET_InLow  in  1  SHALL be the reset, asynchronous and active-low.
REQ-005 SC_LEVELCONTROLLER_start_InHigh  in  1  SHALL be the game start request, sampled each cycle.
REQ-006 SC_LEVELCONTROLLER_pause_InHigh  in  1  SHALL be the pause level; play is held while it is high.
REQ-007 SC_LEVELCONTROLLER_point_InHigh  in  1  SHALL be a 1-cycle pulse per scored event.
REQ-008 SC_LEVELCONTROLLER_upLEVEL_Out  out  1  SHALL be the 1-cycle increment pulse to the 2-bit level counter.
REQ-009 SC_LEVELCONTROLLER_level_OutBUS  out  2  SHALL be the internal mirror of the level counter value.
REQ-010 SC_LEVELCONTROLLER_tick_Out  out  1  SHALL be the 1-cycle game-step tick.
REQ-011 SC_LEVELCONTROLLER_running_Out  out  1  SHALL be high in RUN, LEVELUP and MAX.

Function
REQ-012 The FSM SHALL have the states IDLE, RUN, LEVELUP, PAUSE and MAX.
REQ-013 IDLE SHALL go to RUN when start=1; in IDLE, point, pause and tick SHALL have no effect.
REQ-014 In RUN and MAX, pause=1 SHALL go to PAUSE; PAUSE SHALL return to MAX if level=3, else to RUN, in the cycle after pause=0.
REQ-015 The point counter (8 bits) SHALL increment on each point sampled in RUN; a point arriving when count=POINTS_PER_LEVEL-1 SHALL go to LEVELUP and clear the count.
REQ-016 LEVELUP SHALL last exactly one cycle with upLEVEL_Out=1; level_OutBUS SHALL increment on the closing edge; the next state SHALL be MAX if the new level is 3, else RUN.
REQ-017 A point sampled during LEVELUP SHALL set the count to 1.
REQ-018 Points in MAX, PAUSE and IDLE SHALL be ignored; upLEVEL_Out SHALL never pulse while level=3, so the external counter never wraps.
REQ-019 If pause and point occur in the same cycle in RUN, pause SHALL win and the point SHALL be dropped.
REQ-020 start SHALL be ignored outside IDLE.
REQ-021 The tick period SHALL be TICK_BASE >> level, giving base, /2, /4 and /8 for levels 0..3.
REQ-022 In RUN and MAX, the prescaler SHALL count from 0 to period-1, assert tick_Out for one cycle at period-1, then wrap to 0.
REQ-023 The prescaler SHALL hold its value in PAUSE, clear to 0 on IDLE->RUN, and clear to 0 in LEVELUP; no tick SHALL be issued in LEVELUP.
REQ-024 upLEVEL_Out and tick_Out SHALL be registered outputs; upLEVEL_Out SHALL rise one cycle after the qualifying point is sampled.

Reset
REQ-025 Reset asserted SHALL force the IDLE state, count=0, prescaler=0 and level mirror=0.
REQ-026 While reset is asserted, all outputs SHALL be 0, independent of the clock.
REQ-027 Reset asserted mid-LEVELUP SHALL abort the pulse immediately; the external counter is cleared by the same system reset.
REQ-028 Deassertion SHALL take effect at the next rising clock edge.

Structure
REQ-029 A shared package SHALL hold the state encodings, LEVEL_WIDTH=2, MAX_LEVEL=3 and the prescaler width (25 bits).
REQ-030 The prescaler SHALL be the sub-module sc_tickgen, with inputs period, enable and clear, and output tick.
REQ-031 The FSM and point counter SHALL reside in sc_levelcontroller.

Verification (TICK_BASE=16, POINTS_PER_LEVEL=4)
REQ-032 Reset, then 3 points before start -> all outputs 0, state IDLE, level 0.
REQ-033 Start, then 4 points spaced 3 cycles apart -> exactly one upLEVEL pulse, one cycle after the 4th point; level=1.
REQ-034 Run 64 cycles at level 0, then level up -> ticks every 16 cycles, then every 8 cycles, the first tick coming 8 cycles after LEVELUP.
REQ-035 12 points, then 8 more -> 3 upLEVEL pulses total; level stays 3 in MAX; ticks every 2 cycles.
REQ-036 Pause for 20 cycles at prescaler=5, with 2 points meanwhile -> no tick, count unchanged; after release, the tick comes 11 cycles later at level 0.
REQ-037 Reset asserted during the LEVELUP cycle -> upLEVEL drops immediately; level=0; state IDLE.
